// File: rtl/tictactoe_board_writer_if.sv
// Move-request handshake between a requester and the board writer.
// The requester drives valid/pos; the writer answers with ready and one-cycle ack/illegal pulses.
interface tictactoe_board_writer_if;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       move_ready;
  logic       move_ack;
  logic       illegal;

  modport master (
    output move_valid, move_pos,
    input  move_ready, move_ack, illegal
  );

  modport slave (
    input  move_valid, move_pos,
    output move_ready, move_ack, illegal
  );
endinterface

// File: rtl/tictactoe_board_writer.sv
// Owns the tic-tac-toe board: accepts moves, checks legality, writes cells and alternates turn.
// Locks on game over or a full board until clear or reset.
module tictactoe_board_writer (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            game_over,
  tictactoe_board_writer_if.slave         mv,
  output logic [1:0]                      turn,
  output logic [3:0]                      move_count,
  output logic [1:0]                      pos1,
  output logic [1:0]                      pos2,
  output logic [1:0]                      pos3,
  output logic [1:0]                      pos4,
  output logic [1:0]                      pos5,
  output logic [1:0]                      pos6,
  output logic [1:0]                      pos7,
  output logic [1:0]                      pos8,
  output logic [1:0]                      pos9
);

  typedef enum logic [1:0] {
    ST_READY  = 2'd0,
    ST_WRITE  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_PLAYER = 2'b01;
  localparam logic [1:0] CELL_CPU    = 2'b10;

  state_t          state_r, state_s;
  logic [3:0]      target_r, target_s;
  logic [8:0][1:0] cells_r, cells_s;
  logic [1:0]      turn_r, turn_s;
  logic [3:0]      count_r, count_s;
  logic            ack_r, ack_s;
  logic            illegal_r, illegal_s;
  logic            ready_r;

  // Target must name a real cell (1..9) that is still empty.
  function automatic logic is_legal(input logic [3:0] pos, input logic [8:0][1:0] cells);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (pos == 4'(i + 1)) begin
        ok = (cells[i] == CELL_EMPTY);
      end
    end
    return ok;
  endfunction

  function automatic logic [8:0][1:0] place(input logic [3:0] pos, input logic [8:0][1:0] cells,
                                            input logic [1:0] who);
    logic [8:0][1:0] res;
    res = cells;
    for (int i = 0; i < 9; i++) begin
      if (pos == 4'(i + 1)) begin
        res[i] = who;
      end
    end
    return res;
  endfunction

  // Next-state and next-board decode.
  always_comb begin
    state_s   = state_r;
    target_s  = target_r;
    cells_s   = cells_r;
    turn_s    = turn_r;
    count_s   = count_r;
    ack_s     = 1'b0;
    illegal_s = 1'b0;
    case (state_r)
      ST_READY: begin
        if (game_over) begin
          state_s = ST_LOCKED;
        end else if (mv.move_valid) begin
          target_s = mv.move_pos;
          state_s  = ST_WRITE;
        end else begin
          state_s = ST_READY;
        end
      end
      ST_WRITE: begin
        if (is_legal(target_r, cells_r)) begin
          cells_s = place(target_r, cells_r, turn_r);
          turn_s  = (turn_r == CELL_PLAYER) ? CELL_CPU : CELL_PLAYER;
          count_s = count_r + 4'd1;
          ack_s   = 1'b1;
          // The ninth write fills the board, so no further move may be accepted.
          state_s = (count_r == 4'd8) ? ST_LOCKED : ST_READY;
        end else begin
          illegal_s = 1'b1;
          state_s   = ST_READY;
        end
      end
      ST_LOCKED: begin
        state_s = ST_LOCKED;
      end
      default: begin
        state_s = ST_READY;
      end
    endcase
  end

  // State, board and pulse registers; clear discards any in-flight move.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_READY;
      target_r  <= 4'd0;
      cells_r   <= '0;
      turn_r    <= CELL_PLAYER;
      count_r   <= 4'd0;
      ack_r     <= 1'b0;
      illegal_r <= 1'b0;
      ready_r   <= 1'b1;
    end else if (clear) begin
      state_r   <= ST_READY;
      target_r  <= 4'd0;
      cells_r   <= '0;
      turn_r    <= CELL_PLAYER;
      count_r   <= 4'd0;
      ack_r     <= 1'b0;
      illegal_r <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      state_r   <= state_s;
      target_r  <= target_s;
      cells_r   <= cells_s;
      turn_r    <= turn_s;
      count_r   <= count_s;
      ack_r     <= ack_s;
      illegal_r <= illegal_s;
      ready_r   <= (state_s == ST_READY);
    end
  end

  assign mv.move_ready = ready_r;
  assign mv.move_ack   = ack_r;
  assign mv.illegal    = illegal_r;
  assign turn          = turn_r;
  assign move_count    = count_r;
  assign pos1          = cells_r[0];
  assign pos2          = cells_r[1];
  assign pos3          = cells_r[2];
  assign pos4          = cells_r[3];
  assign pos5          = cells_r[4];
  assign pos6          = cells_r[5];
  assign pos7          = cells_r[6];
  assign pos8          = cells_r[7];
  assign pos9          = cells_r[8];

endmodule

// File: doc/tictactoe_board_writer.md
# tictactoe_board_writer

Sequential board-state owner for the tic-tac-toe datapath. Accepts move requests over a valid/ready handshake, checks legality, writes the 2-bit cell codes, and alternates the turn. It drives the nine cell buses `pos1`..`pos9` that the full-board and winner detectors consume. It freezes the board on game over or when the board is full.

## Interface
- No parameters. Cell encoding is fixed:
  - 2'b00 = empty
  - 2'b01 = player
  - 2'b10 = computer
  - 2'b11 is never written.
- `clock`  in  1  single system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous new-game request.
- `game_over`  in  1  level from the winner/full-board detectors.
- `move_valid`  in  1  move request.
- `move_pos`  in  4  target cell, legal range 1..9.
- `move_ready`  out  1  block can accept a move this cycle.
- `move_ack`  out  1  one-cycle pulse: the move was written.
- `illegal`  out  1  one-cycle pulse: the move was rejected.
- `turn`  out  2  mover of the next accepted move (01 or 10).
- `move_count`  out  4  number of cells written, 0..9.
- `pos1`..`pos9`  out  2 each  cell contents, registered.

## Operation
- States: READY, WRITE, LOCKED.
- `move_ready` = 1 only in READY.
- READY:
  - If `game_over` = 1 → LOCKED. This takes priority over `move_valid`; the move is dropped with no pulse.
  - Else if `move_valid` = 1 → capture `move_pos` and go to WRITE.
  - Else stay in READY.
- WRITE (always exactly one cycle):
  - Legal move: `move_pos` in 1..9 and the target cell is 00.
  - Legal: at the closing edge, write `turn` into the cell, toggle `turn` (01↔10), increment `move_count`, and set `move_ack` for the following cycle.
  - Illegal (0, 10..15, or occupied cell): board, `turn` and `move_count` unchanged; set `illegal` for the following cycle.
  - Next state: LOCKED if `move_count` becomes 9, else READY.
- LOCKED:
  - `move_ready` = 0.
  - `move_valid` is ignored; no `ack` or `illegal` pulse.
  - Exits only via `clear` or `reset`.
- `clear` (sampled at the edge, any state), result at the next cycle:
  - All cells 00, `turn` = 01, `move_count` = 0, state READY.
  - `move_ack` and `illegal` = 0.
  - Any captured or simultaneous move is discarded.
- Priority: `reset` > `clear` > `game_over` > `move_valid`.
- `move_count` never exceeds 9; the lock at 9 guarantees this.
- `move_ack` and `illegal` are never high in the same cycle.

## Timing
- Reset values:
  - `pos1`..`pos9` = 00
  - `turn` = 01
  - `move_count` = 0
  - `move_ack` = 0, `illegal` = 0
  - state READY, so `move_ready` = 1 once reset deasserts.
- Asserting `reset` mid-WRITE aborts the move immediately (asynchronous); no pulse follows.
- Handshake sequence:
  - Cycle N: READY, `move_valid` = 1, accepted at the edge ending N.
  - Cycle N+1: WRITE, `move_ready` = 0.
  - Cycle N+2: updated `pos*` / `turn` / `move_count` visible together with `move_ack` = 1 (or `illegal` = 1 with no state change); READY again.
- Latency from acceptance to visible board: 2 edges.
- Maximum throughput: one move per 2 cycles.
- A `move_valid` held high through WRITE is not re-accepted until READY. The requester drops `move_valid` on `move_ack`/`illegal`, or it is re-sampled as a new move.
- `game_over` is only sampled in READY. It rises combinationally from `pos*` in the `move_ack` cycle, so the lock occurs one edge later, before any further move is accepted.
- All outputs are registered or decoded from state only; no input-to-output combinational path.

## Test plan
- Reset, then release: all `pos` = 00, `turn` = 01, `move_count` = 0, `move_ready` = 1, no pulses.
- Move at 5, then at 1: `pos5` = 01 with `move_ack` at N+2 and `turn` = 10; then `pos1` = 10, `turn` = 01, `move_count` = 2.
- Move at 5 again (occupied), then moves at 0 and 12: `illegal` pulses each time; board, `turn` (01) and `count` (2) unchanged.
- Nine legal alternating moves covering cells 1..9:
  - `move_count` = 9, state LOCKED, `move_ready` = 0.
  - A further `move_valid` produces no `ack` or `illegal`.
  - `pos` ends with cells alternating 01/10 in move order.
- `game_over` forced high in READY together with `move_valid` at cell 3: no write, no pulse, `move_ready` = 0 next cycle. Then `clear` → board empty, `turn` = 01, READY.
- Two mid-operation aborts:
  - `clear` asserted during WRITE of a legal move at 7: `pos7` stays 00, no `move_ack`, `move_count` = 0.
  - `reset` asserted asynchronously mid-cycle: outputs reach their reset values immediately, without waiting for an edge.
